// File: rtl/apb_mem_pkg.sv
// Shared widths and FSM state encoding for the APB memory slave.
package apb_mem_pkg;

   localparam int unsigned DATA_W = 128;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;

   // WAIT is only entered when the wait-state build option is enabled.
   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      WAIT,
      ACCESS,
      DONE
   } state_e;

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB request signals plus the completion/read-data/error response.
interface apb_mem_slave_if;
   import apb_mem_pkg::*;

   logic              PSELx;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] m_rdata;
   logic              m_ready;
   logic              m_error;

   modport master (
      output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
      input  m_rdata, m_ready, m_error
   );

   modport slave (
      input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
      output m_rdata, m_ready, m_error
   );

endinterface

// File: rtl/apb_mem_regfile.sv
// 16 x 128 storage: one write port, one registered read port with clear.
module apb_mem_regfile
   import apb_mem_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic              rclr_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i[ADDR_W-1:0]] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read data holds until the next read or an error-read clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (rclr_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_mem_slave.sv
// APB-style slave over a 16 x 128 register file with protocol-error reporting.
// Build option APB_WAIT_STATE_EN inserts one wait cycle before each transfer.
module apb_mem_slave
   import apb_mem_pkg::*;
(
   input  logic            PCLK,
   input  logic            PRESETn,
   apb_mem_slave_if.slave  bus
);

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic [DATA_W-1:0] wdata_q;
   logic              ready_q;
   logic              error_q;

   logic              access;
   logic              mismatch;
   logic              xfer;
   logic              rf_we;
   logic              rf_re;
   logic              rf_rclr;
   logic [DATA_W-1:0] rf_rdata;

   assign access   = bus.PSELx & bus.PENABLE;
   assign mismatch = (bus.PADDR != addr_q) | (bus.PWRITE != write_q);

`ifdef APB_WAIT_STATE_EN
   assign xfer = (state_q == WAIT) & access;
`else
   assign xfer = (state_q == SETUP) & access;
`endif

   always_comb begin
      rf_we   = 1'b0;
      rf_re   = 1'b0;
      rf_rclr = 1'b0;
      if (xfer) begin
         rf_we   = write_q & ~mismatch;
         rf_re   = ~write_q & ~mismatch;
         rf_rclr = ~write_q & mismatch;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         ready_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.PSELx && !bus.PENABLE) begin
                  state_q <= SETUP;
                  addr_q  <= bus.PADDR;
                  write_q <= bus.PWRITE;
                  wdata_q <= bus.PWDATA;
               end else if (access) begin
                  ready_q <= 1'b1;
                  error_q <= 1'b1;
                  state_q <= DONE;
               end
            end
            SETUP: begin
               if (!bus.PSELx) begin
                  state_q <= IDLE;
               end else if (!bus.PENABLE) begin
                  addr_q  <= bus.PADDR;
                  write_q <= bus.PWRITE;
                  wdata_q <= bus.PWDATA;
               end else begin
`ifdef APB_WAIT_STATE_EN
                  state_q <= WAIT;
`else
                  ready_q <= 1'b1;
                  error_q <= mismatch;
                  state_q <= DONE;
`endif
               end
            end
`ifdef APB_WAIT_STATE_EN
            WAIT: begin
               if (!bus.PSELx) begin
                  state_q <= IDLE;
               end else if (!bus.PENABLE) begin
                  state_q <= SETUP;
                  addr_q  <= bus.PADDR;
                  write_q <= bus.PWRITE;
                  wdata_q <= bus.PWDATA;
               end else begin
                  ready_q <= 1'b1;
                  error_q <= mismatch;
                  state_q <= DONE;
               end
            end
`endif
            DONE: begin
               if (bus.PSELx && !bus.PENABLE) begin
                  state_q <= SETUP;
                  addr_q  <= bus.PADDR;
                  write_q <= bus.PWRITE;
                  wdata_q <= bus.PWDATA;
               end else if (!bus.PSELx) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   apb_mem_regfile u_regfile (
      .clk_i   (PCLK),
      .rst_ni  (PRESETn),
      .we_i    (rf_we),
      .waddr_i (addr_q),
      .wdata_i (wdata_q),
      .re_i    (rf_re),
      .rclr_i  (rf_rclr),
      .raddr_i (addr_q),
      .rdata_o (rf_rdata)
   );

   assign bus.m_rdata = rf_rdata;
   assign bus.m_ready = ready_q;
   assign bus.m_error = error_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench for apb_mem_slave: table-driven transfers with a response scoreboard.
module tb_apb_mem_slave;
   import apb_mem_pkg::*;

   logic PCLK = 1'b0;
   logic PRESETn;

   always #5 PCLK = ~PCLK;

   apb_mem_slave_if bus ();

   apb_mem_slave dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic              ready;
      logic              err;
      logic [DATA_W-1:0] rdata;
      string             name;
   } exp_t;

   typedef struct {
      bit                wr;
      logic [ADDR_W-1:0] addr;
      logic [ADDR_W-1:0] acc_addr;
      logic [DATA_W-1:0] wdata;
      bit                b2b;
      bit                exp_err;
      logic [DATA_W-1:0] exp_rdata;
      string             name;
   } vec_t;

   exp_t              sb[$];
   vec_t              vecs[$];
   logic [DATA_W-1:0] last_rd;

   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic idle_bus();
      bus.PSELx   = 1'b0;
      bus.PENABLE = 1'b0;
   endtask

   task automatic push_exp(input logic r, input logic e, input logic [DATA_W-1:0] d,
                           input string nm);
      exp_t x;
      x.ready = r;
      x.err   = e;
      x.rdata = d;
      x.name  = nm;
      sb.push_back(x);
   endtask

   task automatic pop_cmp();
      exp_t x;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty: got no entry expected one");
      end else begin
         x = sb.pop_front();
         check({x.name, "_ready"}, bus.m_ready, x.ready);
         check({x.name, "_error"}, bus.m_error, x.err);
         check({x.name, "_rdata"}, bus.m_rdata, x.rdata);
      end
   endtask

   task automatic add(input bit wr, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] acc,
                      input logic [DATA_W-1:0] d, input bit b2b, input bit err,
                      input logic [DATA_W-1:0] exp, input string nm);
      vec_t v;
      v.wr        = wr;
      v.addr      = a;
      v.acc_addr  = acc;
      v.wdata     = d;
      v.b2b       = b2b;
      v.exp_err   = err;
      v.exp_rdata = exp;
      v.name      = nm;
      vecs.push_back(v);
   endtask

   task automatic run_vec(input vec_t v);
      logic [DATA_W-1:0] er;
      bus.PSELx   = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = v.wr;
      bus.PADDR   = v.addr;
      bus.PWDATA  = v.wdata;
      tick();
      check({v.name, "_setup_ready"}, bus.m_ready, '0);
      bus.PENABLE = 1'b1;
      bus.PADDR   = v.acc_addr;
      if (v.wr) er = last_rd;
      else if (v.exp_err) er = '0;
      else er = v.exp_rdata;
      if (!v.wr) last_rd = er;
      push_exp(1'b1, v.exp_err, er, v.name);
`ifdef APB_WAIT_STATE_EN
      tick();
      check({v.name, "_wait_ready"}, bus.m_ready, '0);
`endif
      tick();
      pop_cmp();
      if (!v.b2b) begin
         idle_bus();
         tick();
         check({v.name, "_pulse_end_ready"}, bus.m_ready, '0);
         check({v.name, "_pulse_end_error"}, bus.m_error, '0);
      end
   endtask

   task automatic run_all();
      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
      vecs.delete();
   endtask

   initial begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] pat;
      pat     = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
      last_rd = '0;

      PRESETn     = 1'b0;
      bus.PSELx   = 1'b0;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = 1'b0;
      bus.PADDR   = '0;
      bus.PWDATA  = '0;
      tick();
      tick();
      check("reset_ready", bus.m_ready, '0);
      check("reset_error", bus.m_error, '0);
      check("reset_rdata", bus.m_rdata, '0);
      PRESETn = 1'b1;
      tick();

      // Phase 1: basic transfers and a full back-to-back sweep.
      add(1'b0, 4'h3, 4'h3, '0, 1'b0, 1'b0, '0, "rd3_after_reset");
      add(1'b1, 4'hA, 4'hA, pat, 1'b0, 1'b0, '0, "wrA_pattern");
      add(1'b0, 4'hA, 4'hA, '0, 1'b0, 1'b0, pat, "rdA_pattern");
      for (int i = 0; i < 16; i++) begin
         a = i[ADDR_W-1:0];
         add(1'b1, a, a, {32{a}}, (i != 15), 1'b0, '0, $sformatf("b2b_wr_%0h", a));
      end
      for (int i = 0; i < 16; i++) begin
         a = i[ADDR_W-1:0];
         add(1'b0, a, a, '0, (i != 15), 1'b0, {32{a}}, $sformatf("b2b_rd_%0h", a));
      end
      run_all();

      // Enable without setup from IDLE, then hold select+enable in DONE.
      bus.PSELx   = 1'b1;
      bus.PENABLE = 1'b1;
      bus.PWRITE  = 1'b1;
      bus.PADDR   = 4'h4;
      bus.PWDATA  = '1;
      push_exp(1'b1, 1'b1, last_rd, "idle_enable_err");
      tick();
      pop_cmp();
      tick();
      check("done_hold_ready", bus.m_ready, '0);
      check("done_hold_error", bus.m_error, '0);
      idle_bus();
      tick();

      // Setup abandoned by dropping select: no write to 0x3.
      bus.PSELx   = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = 1'b1;
      bus.PADDR   = 4'h3;
      bus.PWDATA  = '0;
      tick();
      idle_bus();
      tick();
      check("abort_ready", bus.m_ready, '0);
      tick();
      check("abort_ready_late", bus.m_ready, '0);

      // Phase 2: error cases leave memory untouched.
      add(1'b0, 4'h4, 4'h4, '0, 1'b0, 1'b0, {32{4'h4}}, "rd4_after_idle_err");
      add(1'b0, 4'h3, 4'h3, '0, 1'b0, 1'b0, {32{4'h3}}, "rd3_after_abort");
      add(1'b1, 4'h2, 4'h5, 128'h1, 1'b0, 1'b1, '0, "wr_addr_mismatch");
      add(1'b0, 4'h2, 4'h2, '0, 1'b0, 1'b0, {32{4'h2}}, "rd2_unchanged");
      add(1'b0, 4'h5, 4'h5, '0, 1'b0, 1'b0, {32{4'h5}}, "rd5_unchanged");
      add(1'b0, 4'h6, 4'h9, '0, 1'b0, 1'b1, '0, "rd_addr_mismatch");
      add(1'b0, 4'hA, 4'hA, '0, 1'b0, 1'b0, {32{4'hA}}, "rdA_nonzero");
      run_all();

      // Reset asserted mid-transfer of a write to 0x7.
      bus.PSELx   = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = 1'b1;
      bus.PADDR   = 4'h7;
      bus.PWDATA  = '1;
      tick();
      bus.PENABLE = 1'b1;
      #2;
      PRESETn = 1'b0;
      #1;
      check("async_rst_ready", bus.m_ready, '0);
      check("async_rst_error", bus.m_error, '0);
      check("async_rst_rdata", bus.m_rdata, '0);
      tick();
      idle_bus();
      PRESETn = 1'b1;
      last_rd = '0;
      tick();

      add(1'b0, 4'h7, 4'h7, '0, 1'b0, 1'b0, '0, "rd7_after_reset");
      add(1'b0, 4'hF, 4'hF, '0, 1'b0, 1'b0, '0, "rdF_after_reset");
      run_all();

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
